// File: rtl/refill_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : refill_control_unit_pkg
//  Description : Shared definitions for the instruction-cache refill sequencer.
//                State encodings and a helper that sizes word-offset fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package refill_control_unit_pkg;

    localparam int         c_STATE_W          = 2;
    localparam logic [1:0] c_ST_IDLE          = 2'd0;
    localparam logic [1:0] c_ST_MEM_REQ       = 2'd1;
    localparam logic [1:0] c_ST_BEATS         = 2'd2;
    localparam logic [1:0] c_ST_ARRAY_UPDATE  = 2'd3;

    // Width of a word offset within a line; a one-word line still gets a
    // one-bit field so port widths never collapse to zero.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/refill_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : refill_beat_counter
//  Description : Counts accepted beats of a line burst and maps each beat to
//                its line-buffer word offset (start offset plus count, wrapping
//                at the line size). Flags the final beat of the burst.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_halt          - freezes the count
//                i_clear         - restart count at zero (new burst)
//                i_en            - advance on an accepted beat
//                i_start_idx     - first word offset of the burst
//                o_word_idx      - word offset of the current beat
//                o_last          - current beat is the last of the line
//  Revision    : 1.0 - initial release
// ============================================================================
module refill_beat_counter #(
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_W          = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_halt,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [IDX_W-1:0] i_start_idx,
    output logic [IDX_W-1:0] o_word_idx,
    output logic             o_last
);

    localparam logic [IDX_W-1:0] c_LAST_CNT = IDX_W'(WORDS_PER_LINE - 1);

    logic [IDX_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_halt) begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_en) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Line size is a power of two, so the IDX_W-bit sum wraps exactly at the
    // line boundary.
    assign o_word_idx = i_start_idx + r_cnt;
    assign o_last     = (r_cnt == c_LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/refill_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : refill_control_unit
//  Description : Instruction-cache miss/refill sequencer. Captures a miss,
//                issues one line request, accepts WORDS_PER_LINE beats
//                (optionally critical-word-first), flags the missed word for
//                early restart, kicks off the array update and counts misses.
//  Ports       : clk, rst                  - clock, sync active-high reset
//                i_halt                    - global stall, freezes all state
//                i_valid/i_cache_hit       - lookup result
//                i_miss_word_idx           - word offset of missed fetch
//                o_ready, o_miss_state     - lookup handshake / busy
//                o_mem_req_*, i_mem_req_ready - line request channel
//                i_mem_beat_*, o_mem_beat_ready - beat channel
//                o_wr_en, o_wr_word_idx    - line-buffer write
//                o_send_missed_word        - forward beat to fetch
//                o_initiate_array_update, i_arrays_update_complete
//                o_refill_error            - refill aborted pulse
//                o_miss_count              - saturating miss counter
//  Revision    : 1.0 - initial release
// ============================================================================
module refill_control_unit
    import refill_control_unit_pkg::*;
#(
    parameter  int WORDS_PER_LINE  = 4,
    parameter  bit CRIT_WORD_FIRST = 1'b1,
    parameter  int CNT_W           = 16,
    localparam int IDX_W           = idx_width(WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_halt,
    input  logic             i_valid,
    input  logic             i_cache_hit,
    input  logic [IDX_W-1:0] i_miss_word_idx,
    output logic             o_ready,
    output logic             o_miss_state,
    output logic             o_mem_req_valid,
    input  logic             i_mem_req_ready,
    output logic [IDX_W-1:0] o_mem_req_word_idx,
    input  logic             i_mem_beat_valid,
    input  logic             i_mem_beat_error,
    output logic             o_mem_beat_ready,
    output logic             o_wr_en,
    output logic [IDX_W-1:0] o_wr_word_idx,
    output logic             o_send_missed_word,
    output logic             o_initiate_array_update,
    input  logic             i_arrays_update_complete,
    output logic             o_refill_error,
    output logic [CNT_W-1:0] o_miss_count
);

    logic [c_STATE_W-1:0] r_state;
    logic [IDX_W-1:0]     r_miss_idx;
    logic                 r_update;
    logic [CNT_W-1:0]     r_miss_count;

    logic             w_st_idle;
    logic             w_st_req;
    logic             w_st_beats;
    logic             w_miss_take;
    logic [IDX_W-1:0] w_miss_idx_in;
    logic [IDX_W-1:0] w_start_idx;
    logic             w_req_fire;
    logic             w_beat_acc;
    logic             w_beat_ok;
    logic             w_beat_err;
    logic [IDX_W-1:0] w_word_idx;
    logic             w_last;

    assign w_st_idle  = (r_state == c_ST_IDLE);
    assign w_st_req   = (r_state == c_ST_MEM_REQ);
    assign w_st_beats = (r_state == c_ST_BEATS);

    assign w_miss_take = w_st_idle & i_valid & ~i_cache_hit & ~i_halt;

    // A one-word line has only offset 0; the one-bit index port is ignored.
    assign w_miss_idx_in = (WORDS_PER_LINE == 1) ? '0 : i_miss_word_idx;
    assign w_start_idx   = CRIT_WORD_FIRST ? r_miss_idx : '0;

    assign w_req_fire = w_st_req & i_mem_req_ready & ~i_halt;
    assign w_beat_acc = i_mem_beat_valid & o_mem_beat_ready;
    assign w_beat_ok  = w_beat_acc & ~i_mem_beat_error;
    assign w_beat_err = w_beat_acc & i_mem_beat_error;

    refill_beat_counter #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_W          (IDX_W)
    ) u_beat_counter (
        .clk         (clk),
        .rst         (rst),
        .i_halt      (i_halt),
        .i_clear     (w_req_fire),
        .i_en        (w_beat_ok),
        .i_start_idx (w_start_idx),
        .o_word_idx  (w_word_idx),
        .o_last      (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_miss_idx   <= '0;
            r_update     <= 1'b0;
            r_miss_count <= '0;
        end else if (!i_halt) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_miss_take) begin
                        r_miss_idx <= w_miss_idx_in;
                        if (r_miss_count != '1) begin
                            r_miss_count <= r_miss_count + 1'b1;
                        end
                        r_state <= c_ST_MEM_REQ;
                    end
                end
                c_ST_MEM_REQ: begin
                    if (w_req_fire) begin
                        r_state <= c_ST_BEATS;
                    end
                end
                c_ST_BEATS: begin
                    if (w_beat_err) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_beat_ok && w_last) begin
                        r_state  <= c_ST_ARRAY_UPDATE;
                        r_update <= 1'b1;
                    end
                end
                c_ST_ARRAY_UPDATE: begin
                    // Request stays up until the first unhalted cycle here.
                    r_update <= 1'b0;
                    if (i_arrays_update_complete) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready                 = w_st_idle & ~i_halt;
    assign o_miss_state            = ~w_st_idle;
    assign o_mem_req_valid         = w_st_req;
    assign o_mem_req_word_idx      = w_st_req ? w_start_idx : '0;
    assign o_mem_beat_ready        = w_st_beats & ~i_halt;
    assign o_wr_en                 = w_beat_ok;
    assign o_wr_word_idx           = w_st_beats ? w_word_idx : '0;
    assign o_send_missed_word      = w_beat_ok & (w_word_idx == r_miss_idx);
    assign o_initiate_array_update = r_update;
    assign o_refill_error          = w_beat_err;
    assign o_miss_count            = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_refill_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_refill_control_unit
//  Description : Scoreboard bench for refill_control_unit. Three instances:
//                A (4 words, critical-word-first, 16-bit count),
//                B (4 words, line-order, 2-bit count),
//                C (1 word, critical-word-first, 16-bit count).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_refill_control_unit;

    localparam logic [1:0] c_EV_REQ = 2'd0;
    localparam logic [1:0] c_EV_WR  = 2'd1;
    localparam logic [1:0] c_EV_ERR = 2'd2;
    localparam logic [1:0] c_EV_UPD = 2'd3;

    typedef struct packed {
        logic [1:0] inst;
        logic [1:0] typ;
        logic [1:0] idx;
        logic       miss;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       halt     [3];
    logic       vld      [3];
    logic       hit      [3];
    logic       rq_rdy   [3];
    logic       bt_vld   [3];
    logic       bt_err   [3];
    logic       upd_done [3];
    logic [1:0] midx     [3];

    wire        rdy    [3];
    wire        mst    [3];
    wire        rq_vld [3];
    wire        bt_rdy [3];
    wire        wr_en  [3];
    wire        smw    [3];
    wire        upd    [3];
    wire        rerr   [3];
    wire [1:0]  rwi    [3];
    wire [1:0]  wwi    [3];
    wire [15:0] mc     [3];

    wire [1:0]  b_mc;
    wire        c_rwi;
    wire        c_wwi;

    refill_control_unit #(.WORDS_PER_LINE(4), .CRIT_WORD_FIRST(1'b1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .i_halt(halt[0]), .i_valid(vld[0]), .i_cache_hit(hit[0]),
        .i_miss_word_idx(midx[0]), .o_ready(rdy[0]), .o_miss_state(mst[0]),
        .o_mem_req_valid(rq_vld[0]), .i_mem_req_ready(rq_rdy[0]), .o_mem_req_word_idx(rwi[0]),
        .i_mem_beat_valid(bt_vld[0]), .i_mem_beat_error(bt_err[0]), .o_mem_beat_ready(bt_rdy[0]),
        .o_wr_en(wr_en[0]), .o_wr_word_idx(wwi[0]), .o_send_missed_word(smw[0]),
        .o_initiate_array_update(upd[0]), .i_arrays_update_complete(upd_done[0]),
        .o_refill_error(rerr[0]), .o_miss_count(mc[0])
    );

    refill_control_unit #(.WORDS_PER_LINE(4), .CRIT_WORD_FIRST(1'b0), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .i_halt(halt[1]), .i_valid(vld[1]), .i_cache_hit(hit[1]),
        .i_miss_word_idx(midx[1]), .o_ready(rdy[1]), .o_miss_state(mst[1]),
        .o_mem_req_valid(rq_vld[1]), .i_mem_req_ready(rq_rdy[1]), .o_mem_req_word_idx(rwi[1]),
        .i_mem_beat_valid(bt_vld[1]), .i_mem_beat_error(bt_err[1]), .o_mem_beat_ready(bt_rdy[1]),
        .o_wr_en(wr_en[1]), .o_wr_word_idx(wwi[1]), .o_send_missed_word(smw[1]),
        .o_initiate_array_update(upd[1]), .i_arrays_update_complete(upd_done[1]),
        .o_refill_error(rerr[1]), .o_miss_count(b_mc)
    );
    assign mc[1] = {14'd0, b_mc};

    refill_control_unit #(.WORDS_PER_LINE(1), .CRIT_WORD_FIRST(1'b1), .CNT_W(16)) u_dut_c (
        .clk(clk), .rst(rst), .i_halt(halt[2]), .i_valid(vld[2]), .i_cache_hit(hit[2]),
        .i_miss_word_idx(midx[2][0:0]), .o_ready(rdy[2]), .o_miss_state(mst[2]),
        .o_mem_req_valid(rq_vld[2]), .i_mem_req_ready(rq_rdy[2]), .o_mem_req_word_idx(c_rwi),
        .i_mem_beat_valid(bt_vld[2]), .i_mem_beat_error(bt_err[2]), .o_mem_beat_ready(bt_rdy[2]),
        .o_wr_en(wr_en[2]), .o_wr_word_idx(c_wwi), .o_send_missed_word(smw[2]),
        .o_initiate_array_update(upd[2]), .i_arrays_update_complete(upd_done[2]),
        .o_refill_error(rerr[2]), .o_miss_count(mc[2])
    );
    assign rwi[2] = {1'b0, c_rwi};
    assign wwi[2] = {1'b0, c_wwi};

    int  n_checks = 0;
    int  n_pass   = 0;
    int  exp_mc   [3] = '{0, 0, 0};
    int  sat_mc   [3] = '{65535, 3, 65535};
    ev_t exp_q    [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input int k, input logic [1:0] typ, input int idx, input logic m);
        ev_t e;
        e.inst = 2'(k);
        e.typ  = typ;
        e.idx  = 2'(idx);
        e.miss = m;
        exp_q.push_back(e);
    endtask

    task automatic got(input int k, input logic [1:0] typ, input logic [1:0] idx, input logic m);
        ev_t a;
        ev_t e;
        a.inst = 2'(k);
        a.typ  = typ;
        a.idx  = idx;
        a.miss = m;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", 32'(a), 32'h7F);
        end else begin
            e = exp_q.pop_front();
            chk("event", 32'(a), 32'(e));
        end
    endtask

    // Monitor: every observable DUT transaction is matched against the queue.
    logic upd_prev [3] = '{1'b0, 1'b0, 1'b0};
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (rq_vld[k] && rq_rdy[k] && !halt[k]) got(k, c_EV_REQ, rwi[k], 1'b0);
                if (wr_en[k]) got(k, c_EV_WR, wwi[k], smw[k]);
                else if (smw[k]) chk("smw_without_wr_en", 32'(smw[k]), 32'd0);
                if (rerr[k]) got(k, c_EV_ERR, 2'd0, 1'b0);
                if (upd[k] && !upd_prev[k]) got(k, c_EV_UPD, 2'd0, 1'b0);
            end
        end
        for (int k = 0; k < 3; k++) upd_prev[k] <= upd[k];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int k, output int cyc);
        cyc = 0;
        @(negedge clk);
        while (!rdy[k] && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input int k);
        chk("idle_flags", 32'({rdy[k], mst[k], rq_vld[k], bt_rdy[k], wr_en[k], smw[k], upd[k], rerr[k]}), 32'h80);
        chk("idle_idx", 32'({rwi[k], wwi[k]}), 32'd0);
        chk("idle_miss_count", 32'(mc[k]), exp_mc[k]);
    endtask

    // Full miss against zero-wait memory; expected beat order from line geometry.
    task automatic run_miss(input int k, input int idx, input int n, input bit cwf);
        int start;
        int w;
        int cyc;
        start = cwf ? idx : 0;
        push(k, c_EV_REQ, start, 1'b0);
        for (int i = 0; i < n; i++) begin
            w = (start + i) % n;
            push(k, c_EV_WR, w, w == idx);
        end
        push(k, c_EV_UPD, 0, 1'b0);
        if (exp_mc[k] < sat_mc[k]) exp_mc[k]++;
        tick();
        vld[k] = 1'b1;
        midx[k] = 2'(idx);
        tick();
        vld[k] = 1'b0;
        wait_ready(k, cyc);
        chk("refill_latency", 32'(cyc), 32'(n + 2));
        chk("miss_count", 32'(mc[k]), exp_mc[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            halt[k] = 1'b0; vld[k] = 1'b0; hit[k] = 1'b0; midx[k] = 2'd0;
            rq_rdy[k] = 1'b0; bt_vld[k] = 1'b0; bt_err[k] = 1'b0; upd_done[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        halt[0] = 1'b1;
        @(negedge clk);
        chk("reset_ready_halted", 32'(rdy[0]), 32'd0);
        tick();
        halt[0] = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rq_rdy[k] = 1'b1; bt_vld[k] = 1'b1; upd_done[k] = 1'b1;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_idle(k);

        // Critical-word-first miss at word 2: req 2, writes 2,3,0,1.
        run_miss(0, 2, 4, 1'b1);

        // Hit and halted miss are both ignored.
        tick();
        vld[0] = 1'b1; hit[0] = 1'b1; midx[0] = 2'd1;
        tick();
        hit[0] = 1'b0; halt[0] = 1'b1;
        @(negedge clk);
        chk("halt_idle_not_ready", 32'(rdy[0]), 32'd0);
        tick();
        vld[0] = 1'b0; halt[0] = 1'b0;
        @(negedge clk);
        chk("ignored_no_refill", 32'({mst[0], mc[0]}), 32'(exp_mc[0]));

        // Halt during request and mid-burst.
        push(0, c_EV_REQ, 1, 1'b0);
        push(0, c_EV_WR, 1, 1'b1);
        push(0, c_EV_WR, 2, 1'b0);
        push(0, c_EV_WR, 3, 1'b0);
        push(0, c_EV_WR, 0, 1'b0);
        push(0, c_EV_UPD, 0, 1'b0);
        exp_mc[0]++;
        tick();
        vld[0] = 1'b1; midx[0] = 2'd1;
        tick();
        vld[0] = 1'b0; halt[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("halt_req_held", 32'({rq_vld[0], mst[0], rwi[0]}), 32'b1101);
            tick();
        end
        halt[0] = 1'b0;
        tick();
        tick();
        halt[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("halt_beats_frozen", 32'({bt_rdy[0], wr_en[0], mst[0]}), 32'b001);
            tick();
        end
        halt[0] = 1'b0;
        wait_ready(0, cyc);
        chk("halt_resume_latency", 32'(cyc), 32'd4);
        chk("halt_miss_count", 32'(mc[0]), exp_mc[0]);

        // Line-order fetch: req 0, missed word 3 forwarded with last beat.
        run_miss(1, 3, 4, 1'b0);
        // Two-bit counter saturates at 3 after five misses.
        repeat (4) run_miss(1, 0, 4, 1'b0);
        // One-word line completes after a single beat.
        run_miss(2, 0, 1, 1'b1);

        // Reset in the middle of a burst.
        push(0, c_EV_REQ, 0, 1'b0);
        push(0, c_EV_WR, 0, 1'b1);
        push(0, c_EV_WR, 1, 1'b0);
        tick();
        vld[0] = 1'b1; midx[0] = 2'd0;
        tick();
        vld[0] = 1'b0;
        tick();
        tick();
        tick();
        bt_vld[0] = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; bt_vld[0] = 1'b1;
        for (int k = 0; k < 3; k++) exp_mc[k] = 0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_idle(k);

        // Error on the second beat aborts the refill.
        push(0, c_EV_REQ, 0, 1'b0);
        push(0, c_EV_WR, 0, 1'b1);
        push(0, c_EV_ERR, 0, 1'b0);
        exp_mc[0]++;
        tick();
        vld[0] = 1'b1; midx[0] = 2'd0;
        tick();
        vld[0] = 1'b0;
        tick();
        tick();
        bt_err[0] = 1'b1;
        @(negedge clk);
        chk("error_no_update", 32'(upd[0]), 32'd0);
        tick();
        bt_err[0] = 1'b0;
        @(negedge clk);
        chk("error_back_idle", 32'({rdy[0], mst[0], upd[0]}), 32'b100);
        chk("error_miss_count", 32'(mc[0]), 32'd1);

        // Clean refills after abort and after reset.
        run_miss(0, 3, 4, 1'b1);
        run_miss(1, 2, 4, 1'b0);

        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
